gs_banded_register_file: RTL

// Parametrised operand store for the Gauss-Seidel solver. Holds the N-entry right-hand side b and solution x.

---
 rtl/gs_banded_register_file_pkg.sv | 33 +++
 rtl/gs_banded_register_file_tap_select.sv | 56 +++++
 rtl/gs_banded_register_file.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/gs_banded_register_file_pkg.sv
// Shared types and helpers for the Gauss-Seidel banded operand store.
// Contents: FSM state enum, address-width helper, edge tap-mask function.
package gs_banded_register_file_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } gs_state_t;

  // Width of a row/address counter for an n-entry store (at least 1 bit).
  function automatic int addr_w(input int n);
    int w;
    if (n > 1) begin
      w = $clog2(n);
    end else begin
      w = 1;
    end
    return w;
  endfunction

  // True when row+off lies inside the matrix, i.e. the tap is not edge-masked.
  function automatic logic tap_ok(input int row, input int off, input int n);
    logic ok;
    if ((row + off >= 0) && (row + off < n)) begin
      ok = 1'b1;
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/gs_banded_register_file_tap_select.sv
// Combinational gather of the 2*BAND neighbour taps for one row.
// Ports:
//   x        in  stored solution vector (flop array)
//   row      in  row being issued
//   fwd_en   in  a writeback of row-1 lands this cycle
//   fwd_data in  the value being written back
//   x_lo     out slice k = x[row-1-k] (0 past the top edge), slice 0 bypassed
//   x_hi     out slice k = x[row+1+k] (0 past the bottom edge)
module gs_banded_register_file_tap_select
  import gs_banded_register_file_pkg::*;
#(
  parameter int N    = 16,
  parameter int BAND = 3,
  parameter int X_W  = 32,
  parameter int AW   = 4
) (
  input  logic [X_W-1:0]      x [N],
  input  logic [AW-1:0]       row,
  input  logic                fwd_en,
  input  logic [X_W-1:0]      fwd_data,
  output logic [BAND*X_W-1:0] x_lo,
  output logic [BAND*X_W-1:0] x_hi
);

  int row_i_s;
  int lo_i_s;
  int hi_i_s;

  // Edge-masked tap gather; the slice-0 bypass only applies when the tap is in range.
  always_comb begin
    x_lo    = '0;
    x_hi    = '0;
    row_i_s = int'(row);
    lo_i_s  = 0;
    hi_i_s  = 0;
    for (int k = 0; k < BAND; k++) begin
      lo_i_s = row_i_s - 1 - k;
      hi_i_s = row_i_s + 1 + k;
      if (tap_ok(row_i_s, -1 - k, N)) begin
        if ((k == 0) && fwd_en) begin
          x_lo[k*X_W +: X_W] = fwd_data;
        end else begin
          x_lo[k*X_W +: X_W] = x[AW'(lo_i_s)];
        end
      end else begin
        x_lo[k*X_W +: X_W] = '0;
      end
      if (tap_ok(row_i_s, 1 + k, N)) begin
        x_hi[k*X_W +: X_W] = x[AW'(hi_i_s)];
      end else begin
        x_hi[k*X_W +: X_W] = '0;
      end
    end
  end

endmodule

// File: rtl/gs_banded_register_file.sv
// Operand store for the Gauss-Seidel solver: loads b, streams rows with banded
// x neighbours, accepts in-order writebacks, runs a set number of sweeps.
// Ports:
//   clk_in/rst_n_in                      clock, async active-low reset
//   b_valid_in/b_in/b_ready_out          b load stream (IDLE only)
//   iter_max_in                          sweep count, latched on last b word
//   row_valid_out/row_ready_in           row issue handshake
//   row_idx_out/b_out/x_lo_out/x_hi_out  issued row operands (0 when not valid)
//   x_valid_in/x_in                      writeback of oldest outstanding row
//   sweep_out/done_out/clear_in          progress, completion, return to IDLE
//   rd_addr_in/rd_data_out               combinational x readout
//   err_out                              sticky stray-writeback flag
module gs_banded_register_file
  import gs_banded_register_file_pkg::*;
#(
  parameter  int N      = 16,
  parameter  int BAND   = 3,
  parameter  int B_W    = 16,
  parameter  int X_W    = 32,
  parameter  int ITER_W = 8,
  localparam int AW     = addr_w(N)
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                b_valid_in,
  input  logic [B_W-1:0]      b_in,
  output logic                b_ready_out,
  input  logic [ITER_W-1:0]   iter_max_in,
  output logic                row_valid_out,
  input  logic                row_ready_in,
  output logic [AW-1:0]       row_idx_out,
  output logic [B_W-1:0]      b_out,
  output logic [BAND*X_W-1:0] x_lo_out,
  output logic [BAND*X_W-1:0] x_hi_out,
  input  logic                x_valid_in,
  input  logic [X_W-1:0]      x_in,
  output logic [ITER_W-1:0]   sweep_out,
  output logic                done_out,
  input  logic                clear_in,
  input  logic [AW-1:0]       rd_addr_in,
  output logic [X_W-1:0]      rd_data_out,
  output logic                err_out
);

  localparam logic [AW-1:0] LAST_ROW = AW'(N - 1);

  gs_state_t             state_r, state_next_s;
  logic [B_W-1:0]        b_r [N];
  logic [X_W-1:0]        x_r [N];
  logic [AW-1:0]         ld_cnt_r, row_r, wr_ptr_r;
  logic [ITER_W-1:0]     iter_r, sweep_r;
  logic                  outst_r, err_r;
  logic                  b_hs_s, last_b_s, stop_s, row_valid_s, issue_s;
  logic                  wb_s, last_wb_s, clear_s;
  logic [BAND*X_W-1:0]   lo_s, hi_s;

  // Handshake and hazard decode; at most one row is ever outstanding.
  always_comb begin
    b_hs_s      = (state_r == ST_IDLE) && b_valid_in;
    last_b_s    = b_hs_s && (ld_cnt_r == LAST_ROW);
    stop_s      = (sweep_r == iter_r);
    row_valid_s = (state_r == ST_RUN) && !stop_s && (!outst_r || x_valid_in);
    issue_s     = row_valid_s && row_ready_in;
    wb_s        = x_valid_in && outst_r;
    last_wb_s   = wb_s && stop_s && (wr_ptr_r == LAST_ROW);
    clear_s     = (state_r == ST_DONE) && clear_in;
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (last_b_s) state_next_s = ST_RUN;
        else          state_next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_wb_s) state_next_s = ST_DONE;
        else           state_next_s = ST_RUN;
      end
      ST_DONE: begin
        if (clear_in) state_next_s = ST_IDLE;
        else          state_next_s = ST_DONE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_r <= ST_IDLE;
    else           state_r <= state_next_s;
  end

  // b and x storage; clear wipes x but keeps b until the next load.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < N; i++) begin
        b_r[i] <= '0;
        x_r[i] <= '0;
      end
    end else if (clear_s) begin
      for (int i = 0; i < N; i++) x_r[i] <= '0;
    end else begin
      if (b_hs_s) b_r[ld_cnt_r] <= b_in;
      if (wb_s)   x_r[wr_ptr_r] <= x_in;
    end
  end

  // Load, issue, writeback and sweep counters.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ld_cnt_r <= '0;
      row_r    <= '0;
      wr_ptr_r <= '0;
      iter_r   <= '0;
      sweep_r  <= '0;
      outst_r  <= 1'b0;
    end else if (clear_s) begin
      ld_cnt_r <= '0;
      row_r    <= '0;
      wr_ptr_r <= '0;
      iter_r   <= '0;
      sweep_r  <= '0;
      outst_r  <= 1'b0;
    end else if (b_hs_s) begin
      if (last_b_s) begin
        ld_cnt_r <= '0;
        row_r    <= '0;
        wr_ptr_r <= '0;
        sweep_r  <= '0;
        outst_r  <= 1'b0;
        // A zero sweep request still runs one sweep.
        iter_r   <= (iter_max_in == '0) ? ITER_W'(1) : iter_max_in;
      end else begin
        ld_cnt_r <= ld_cnt_r + AW'(1);
      end
    end else begin
      if (issue_s) begin
        if (row_r == LAST_ROW) begin
          row_r   <= '0;
          sweep_r <= sweep_r + ITER_W'(1);
        end else begin
          row_r   <= row_r + AW'(1);
        end
      end
      if (wb_s) begin
        wr_ptr_r <= (wr_ptr_r == LAST_ROW) ? '0 : wr_ptr_r + AW'(1);
      end
      // Issue and writeback together leave the outstanding count unchanged.
      if (issue_s && !wb_s)      outst_r <= 1'b1;
      else if (wb_s && !issue_s) outst_r <= 1'b0;
      else                       outst_r <= outst_r;
    end
  end

  // Sticky error: a writeback arrived with no row outstanding.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                   err_r <= 1'b0;
    else if (x_valid_in && !outst_r) err_r <= 1'b1;
    else                             err_r <= err_r;
  end

  gs_banded_register_file_tap_select #(
    .N    (N),
    .BAND (BAND),
    .X_W  (X_W),
    .AW   (AW)
  ) u_tap_select (
    .x        (x_r),
    .row      (row_r),
    .fwd_en   (wb_s),
    .fwd_data (x_in),
    .x_lo     (lo_s),
    .x_hi     (hi_s)
  );

  // Output drive; row operands are zeroed whenever no row is offered.
  always_comb begin
    b_ready_out   = (state_r == ST_IDLE);
    done_out      = (state_r == ST_DONE);
    row_valid_out = row_valid_s;
    sweep_out     = sweep_r;
    err_out       = err_r;
    if (row_valid_s) begin
      row_idx_out = row_r;
      b_out       = b_r[row_r];
      x_lo_out    = lo_s;
      x_hi_out    = hi_s;
    end else begin
      row_idx_out = '0;
      b_out       = '0;
      x_lo_out    = '0;
      x_hi_out    = '0;
    end
    if ({1'b0, rd_addr_in} < (AW + 1)'(N)) begin
      rd_data_out = x_r[rd_addr_in];
    end else begin
      rd_data_out = '0;
    end
  end

endmodule
